// File: rtl/ifetch_queue_if.sv
// Fetch-side bus bundle: pc_mips feedback, instruction memory port, decode handshake
// and execute redirect.
interface ifetch_queue_if;
   logic [31:0] pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        ex_redirect;
   logic [31:0] ex_target;
   logic        fetch_redirect;
   logic [31:0] fetch_target;

   modport master (
      input  pc, imem_rdata, dec_ready, ex_redirect, ex_target,
      output imem_addr, dec_valid, dec_instr, dec_pc, fetch_redirect, fetch_target
   );

   modport slave (
      output pc, imem_rdata, dec_ready, ex_redirect, ex_target,
      input  imem_addr, dec_valid, dec_instr, dec_pc, fetch_redirect, fetch_target
   );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: pairs imem words with their pc, buffers them for decode,
// and re-steers pc_mips on overflow (replay) or execute redirect.
//
// state  | meaning
// RUN    | normal fetch, s1 words pushed into the queue
// WAIT   | overflow seen, dropping s1 words until the queue has room
// REDIR  | fetch_redirect asserted toward pc_mips with replay_pc
// SETTLE | pc_mips still emitting the pre-redirect address, drop it
module ifetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   ifetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {RUN, WAIT, REDIR, SETTLE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   s1_pc;
   logic          s1_valid;
   logic [31:0]   replay_pc;
   logic [31:0]   replay_nxt;
   logic          fetch_redirect_q;
   logic [31:0]   fetch_target_q;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   q_pc    [DEPTH];
   logic [31:0]   q_instr [DEPTH];

   logic          full;
   logic          pop;
   logic          push;

   assign bus.imem_addr      = bus.pc;
   assign bus.dec_valid      = (count != '0);
   assign bus.dec_pc         = q_pc[rd_ptr];
   assign bus.dec_instr      = q_instr[rd_ptr];
   assign bus.fetch_redirect = fetch_redirect_q;
   assign bus.fetch_target   = fetch_target_q;

   assign full = (count == FULL_CNT);
   assign pop  = bus.dec_valid && bus.dec_ready;

   always_comb begin
      state_nxt  = state;
      replay_nxt = replay_pc;
      push       = 1'b0;
      if (bus.ex_redirect) begin
         state_nxt  = REDIR;
         replay_nxt = bus.ex_target;
      end else begin
         case (state)
            RUN: begin
               if (s1_valid) begin
                  if (!full || pop) begin
                     push = 1'b1;
                  end else begin
                     replay_nxt = s1_pc;
                     state_nxt  = WAIT;
                  end
               end
            end
            WAIT:    if (!full || pop) state_nxt = REDIR;
            REDIR:   state_nxt = SETTLE;
            SETTLE:  state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= RUN;
         s1_pc            <= '0;
         s1_valid         <= 1'b0;
         replay_pc        <= '0;
         fetch_redirect_q <= 1'b0;
         fetch_target_q   <= '0;
      end else begin
         state            <= state_nxt;
         s1_pc            <= bus.pc;
         s1_valid         <= 1'b1;
         replay_pc        <= replay_nxt;
         // Registered so the pulse lines up exactly with the REDIR state.
         fetch_redirect_q <= (state_nxt == REDIR);
         if (state_nxt == REDIR) fetch_target_q <= replay_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else if (bus.ex_redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            q_pc[wr_ptr]    <= s1_pc;
            q_instr[wr_ptr] <= bus.imem_rdata;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a pc_mips model and a one-cycle imem model.
module tb_ifetch_queue;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ifetch_queue_if bus();

   ifetch_queue #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.pc <= 32'h0;
      else        bus.pc <= bus.fetch_redirect ? bus.fetch_target : bus.pc + 32'd4;
   end

   always @(posedge clk) bus.imem_rdata <= bus.imem_addr ^ 32'hA5A5_0000;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] pop_q[$];
   logic [31:0] redir_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_seq(input string tag, input logic [31:0] base, input int n);
      chk({tag, "_len"}, 32'(pop_q.size() >= n), 32'd1);
      for (int i = 0; i < n; i++)
         if (i < pop_q.size()) chk(tag, pop_q[i], base + 32'(4 * i));
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.dec_valid && bus.dec_ready) begin
            pop_q.push_back(bus.dec_pc);
            chk("instr_pair", bus.dec_instr, bus.dec_pc ^ 32'hA5A5_0000);
         end
         if (bus.fetch_redirect) redir_q.push_back(bus.fetch_target);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n           = 1'b0;
      bus.dec_ready   = 1'b1;
      bus.ex_redirect = 1'b0;
      bus.ex_target   = 32'h0;
      #2;
      chk("rst_dec_valid", bus.dec_valid, 0);
      chk("rst_fredir", bus.fetch_redirect, 0);
      chk("rst_ftarget", bus.fetch_target, 0);

      // Latency and streaming from reset
      cyc(2);
      rst_n = 1'b1;
      @(negedge clk) chk("lat_c0", bus.dec_valid, 0);
      @(negedge clk) chk("lat_c1", bus.dec_valid, 0);
      @(negedge clk) chk("lat_c2", bus.dec_valid, 1);
      chk("lat_pc", bus.dec_pc, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk) chk("t1_pc", bus.dec_pc, 32'(4 * i));
      end

      // Overflow with decode stalled from reset, then replay
      cyc(1);
      rst_n = 1'b0;
      bus.dec_ready = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      pop_q.delete();
      redir_q.delete();
      cyc(9);
      @(negedge clk);
      chk("t2_count", 32'(dut.count), 32'd4);
      chk("t2_head", bus.dec_pc, 32'h0);
      chk("t2_noredir", bus.fetch_redirect, 0);
      @(posedge clk); #1;
      bus.dec_ready = 1'b1;
      @(negedge clk) chk("t2_redir_c10", bus.fetch_redirect, 0);
      @(negedge clk) chk("t2_redir_c11", bus.fetch_redirect, 1);
      chk("t2_target", bus.fetch_target, 32'h10);
      @(posedge clk); #1;
      cyc(10);
      chk("t2_nredir", 32'(redir_q.size()), 32'd1);
      if (redir_q.size() > 0) chk("t2_redir_val", redir_q[0], 32'h10);
      check_seq("t2_seq", 32'h0, 10);

      // Fill to DEPTH, then simultaneous push/pop while full
      bus.dec_ready = 1'b0;
      cyc(3);
      bus.dec_ready = 1'b1;
      @(negedge clk);
      chk("t3_full", 32'(dut.count), 32'd4);
      chk("t3_noredir", bus.fetch_redirect, 0);
      @(negedge clk);
      chk("t3_full2", 32'(dut.count), 32'd4);
      cyc(8);
      chk("t3_nredir", 32'(redir_q.size()), 32'd1);
      check_seq("t3_seq", 32'h0, 16);

      // Execute redirect with three entries queued
      rst_n = 1'b0;
      bus.dec_ready = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(4);
      bus.ex_redirect = 1'b1;
      bus.ex_target   = 32'h200;
      @(negedge clk) chk("t4_count3", 32'(dut.count), 32'd3);
      @(posedge clk); #1;
      bus.ex_redirect = 1'b0;
      bus.dec_ready   = 1'b1;
      pop_q.delete();
      redir_q.delete();
      @(negedge clk);
      chk("t4_flush", bus.dec_valid, 0);
      chk("t4_redir", bus.fetch_redirect, 1);
      chk("t4_target", bus.fetch_target, 32'h200);
      cyc(10);
      chk("t4_nredir", 32'(redir_q.size()), 32'd1);
      check_seq("t4_seq", 32'h200, 4);

      // Execute redirect during WAIT overrides the pending replay
      bus.dec_ready   = 1'b0;
      bus.ex_redirect = 1'b1;
      bus.ex_target   = 32'h30;
      cyc(1);
      bus.ex_redirect = 1'b0;
      cyc(12);
      redir_q.delete();
      pop_q.delete();
      @(negedge clk);
      chk("t5_head", bus.dec_pc, 32'h30);
      chk("t5_valid", bus.dec_valid, 1);
      chk("t5_count", 32'(dut.count), 32'd4);
      @(posedge clk); #1;
      bus.ex_redirect = 1'b1;
      bus.ex_target   = 32'h300;
      cyc(1);
      bus.ex_redirect = 1'b0;
      @(negedge clk);
      chk("t5_redir", bus.fetch_redirect, 1);
      chk("t5_target", bus.fetch_target, 32'h300);
      @(posedge clk); #1;
      bus.dec_ready = 1'b1;
      cyc(10);
      chk("t5_nredir", 32'(redir_q.size()), 32'd1);
      if (redir_q.size() > 0) chk("t5_redir_val", redir_q[0], 32'h300);
      check_seq("t5_seq", 32'h300, 4);

      // Asynchronous reset mid-stream
      @(negedge clk);
      chk("t6_pre_valid", bus.dec_valid, 1);
      chk("t6_pre_target", bus.fetch_target, 32'h300);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", bus.dec_valid, 0);
      chk("t6_redir", bus.fetch_redirect, 0);
      chk("t6_target", bus.fetch_target, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pop_q.delete();
      redir_q.delete();
      cyc(8);
      chk("t6_nredir", 32'(redir_q.size()), 32'd0);
      check_seq("t6_seq", 32'h0, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
